// File: rtl/csa_final_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : csa_final_adder_pipe
// Purpose  : Two-stage elastic carry-propagate adder that resolves the
//            sum/carry pair from the multiplier's compressor tree.
// Revision : 1.0 - initial release
// ============================================================================
module csa_final_adder_pipe #(
    parameter int W     = 128,
    parameter int SPLIT = 64,
    parameter int TAG_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_prod,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf
);

    localparam int HI_W = W - SPLIT;

    logic [W-1:0]     w_b;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [HI_W:0]    w_hi;

    logic             s1_valid_q,  s1_valid_d;
    logic [SPLIT:0]   s1_lo_q,     s1_lo_d;
    logic [HI_W-1:0]  s1_sum_hi_q, s1_sum_hi_d;
    logic [HI_W-1:0]  s1_b_hi_q,   s1_b_hi_d;
    logic             s1_cmsb_q,   s1_cmsb_d;
    logic [TAG_W-1:0] s1_tag_q,    s1_tag_d;

    logic             s2_valid_q,  s2_valid_d;
    logic [W-1:0]     s2_prod_q,   s2_prod_d;
    logic             s2_ovf_q,    s2_ovf_d;
    logic [TAG_W-1:0] s2_tag_q,    s2_tag_d;

    // Carry vector bit i carries weight 2^(i+1); its MSB falls off and feeds ovf.
    assign w_b      = {in_carry[W-2:0], 1'b0};
    assign w_s2_adv = ~s2_valid_q | out_ready;
    assign w_s1_adv = ~s1_valid_q | w_s2_adv;
    assign in_ready = w_s1_adv;

    assign w_hi = {1'b0, s1_sum_hi_q} + {1'b0, s1_b_hi_q}
                + {{HI_W{1'b0}}, s1_lo_q[SPLIT]};

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_lo_d     = s1_lo_q;
        s1_sum_hi_d = s1_sum_hi_q;
        s1_b_hi_d   = s1_b_hi_q;
        s1_cmsb_d   = s1_cmsb_q;
        s1_tag_d    = s1_tag_q;
        s2_valid_d  = s2_valid_q;
        s2_prod_d   = s2_prod_q;
        s2_ovf_d    = s2_ovf_q;
        s2_tag_d    = s2_tag_q;

        if (w_s1_adv) begin
            s1_valid_d = in_valid;
            // Data only captured with a real transaction to avoid idle toggling.
            if (in_valid) begin
                s1_lo_d     = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, w_b[SPLIT-1:0]};
                s1_sum_hi_d = in_sum[W-1:SPLIT];
                s1_b_hi_d   = w_b[W-1:SPLIT];
                s1_cmsb_d   = in_carry[W-1];
                s1_tag_d    = in_tag;
            end
        end

        if (w_s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_d = {w_hi[HI_W-1:0], s1_lo_q[SPLIT-1:0]};
                s2_ovf_d  = w_hi[HI_W] | s1_cmsb_q;
                s2_tag_d  = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= '0;
            s1_sum_hi_q <= '0;
            s1_b_hi_q   <= '0;
            s1_cmsb_q   <= 1'b0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_prod_q   <= '0;
            s2_ovf_q    <= 1'b0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_sum_hi_q <= s1_sum_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
            s1_cmsb_q   <= s1_cmsb_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_prod_q   <= s2_prod_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_prod  = s2_prod_q;
    assign out_tag   = s2_tag_q;
    assign out_ovf   = s2_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_csa_final_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_final_adder_pipe
// Purpose  : Directed and randomised self-checking bench for the final adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_final_adder_pipe;

    localparam int W     = 128;
    localparam int SPLIT = 64;
    localparam int TAG_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sum;
    logic [W-1:0]     in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_prod;
    logic [TAG_W-1:0] out_tag;
    logic             out_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0]     prod;
        logic [TAG_W-1:0] tag;
        logic             ovf;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    csa_final_adder_pipe #(.W(W), .SPLIT(SPLIT), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf)
    );

    // Plain full-width reference: sum + (carry << 1) with a 129-bit result.
    function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] c,
                                   input logic [TAG_W-1:0] t);
        logic [W:0] full;
        exp_t e;
        full   = {1'b0, s} + {1'b0, c[W-2:0], 1'b0};
        e.prod = full[W-1:0];
        e.ovf  = full[W] | c[W-1];
        e.tag  = t;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sum = '0; in_carry = '0; in_tag = '0;
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_prod !== '0) begin failures++; $display("FAIL reset_out_prod got=%h exp=0", out_prod); end
        checks++; if (out_tag !== '0 || out_ovf !== 1'b0) begin failures++; $display("FAIL reset_tag_ovf got=%h/%0b exp=0/0", out_tag, out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_idle got=%0b/%0b exp=0/1", out_valid, in_ready); end
    endtask

    task automatic test_split_carry();
        out_ready = 1'b1; in_valid = 1'b1;
        in_sum = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
        in_carry = 128'd1; in_tag = 12'h5A5;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL split_in_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL split_latency1 got=%0b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL split_latency2 got=%0b exp=1", out_valid); end
        checks++; if (out_prod !== 128'h0000_0000_0000_0001_0000_0000_0000_0001) begin failures++; $display("FAIL split_prod got=%h exp=%h", out_prod, 128'h0000_0000_0000_0001_0000_0000_0000_0001); end
        checks++; if (out_ovf !== 1'b0 || out_tag !== 12'h5A5) begin failures++; $display("FAIL split_ovf_tag got=%0b/%h exp=0/5a5", out_ovf, out_tag); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL split_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_top_wrap();
        out_ready = 1'b1; in_valid = 1'b1;
        in_sum   = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        in_carry = 128'hC000_0000_0000_0000_0000_0000_0000_0000;
        in_tag   = 12'hFFF;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || out_prod !== '0) begin failures++; $display("FAIL wrap_prod got=%0b/%h exp=1/0", out_valid, out_prod); end
        checks++; if (out_ovf !== 1'b1 || out_tag !== 12'hFFF) begin failures++; $display("FAIL wrap_ovf_tag got=%0b/%h exp=1/fff", out_ovf, out_tag); end
        tick();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_valid = 1'b1;
        in_sum = 128'h1234; in_carry = 128'h10; in_tag = 12'd1;
        tick();
        in_sum = 128'h5678; in_carry = 128'h20; in_tag = 12'd2;
        tick();
        in_sum = 128'h9ABC; in_carry = 128'h30; in_tag = 12'd3;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_full got=%0b/%0b exp=0/1", in_ready, out_valid); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0b exp=0", out_valid); end
        checks++; if (out_prod !== '0 || out_tag !== '0 || out_ovf !== 1'b0) begin failures++; $display("FAIL mid_rst_data got=%h/%h/%0b exp=0", out_prod, out_tag, out_ovf); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%0b exp=1", in_ready); end
        tick();
        #2;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale cyc=%0d got=%0b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] s[5];
        logic [W-1:0] c[5];
        exp_t e[5];
        int idx;
        int rx;
        logic acc;
        for (int i = 0; i < 5; i++) begin
            s[i] = rnd128(); c[i] = rnd128();
            e[i] = model(s[i], c[i], TAG_W'(i + 1));
        end
        idx = 0; rx = 0; out_ready = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin in_sum = s[idx]; in_carry = c[idx]; in_tag = TAG_W'(idx + 1); end
            #1;
            if (cyc >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_tag !== 12'd1 || out_prod !== e[0].prod) begin failures++; $display("FAIL bp_stable cyc=%0d got=%0b/%h/%h exp=1/001/%h", cyc, out_valid, out_tag, out_prod, e[0].prod); end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        checks++; if (idx !== 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", idx); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && rx < 5; cyc++) begin
            in_valid = (idx < 5);
            if (idx < 5) begin in_sum = s[idx]; in_carry = c[idx]; in_tag = TAG_W'(idx + 1); end
            #1;
            if (out_valid && out_ready) begin
                checks++; if ({out_prod, out_tag, out_ovf} !== e[rx]) begin failures++; $display("FAIL bp_order n=%0d got=%h/%h/%0b exp=%h/%h/%0b", rx, out_prod, out_tag, out_ovf, e[rx].prod, e[rx].tag, e[rx].ovf); end
                rx++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checks++; if (rx !== 5) begin failures++; $display("FAIL bp_count got=%0d exp=5", rx); end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        int sent;
        int rx;
        logic have;
        logic acc;
        exp_t e;
        sent = 0; rx = 0; have = 1'b0; out_ready = 1'b1;
        sb.delete();
        for (int k = 0; k < 1002; k++) begin
            if (!have && sent < 1000) begin
                in_sum = rnd128(); in_carry = rnd128(); in_tag = TAG_W'($urandom());
                have = 1'b1;
            end
            in_valid = have;
            #1;
            if (in_valid) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready k=%0d got=%0b exp=1", k, in_ready); end
            end
            if (k >= 2) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_gap k=%0d got=%0b exp=1", k, out_valid); end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++; $display("FAIL b2b_extra k=%0d got=%h exp=none", k, out_prod);
                end else begin
                    e = sb.pop_front();
                    checks++; if ({out_prod, out_tag, out_ovf} !== e) begin failures++; $display("FAIL b2b_data n=%0d got=%h/%h/%0b exp=%h/%h/%0b", rx, out_prod, out_tag, out_ovf, e.prod, e.tag, e.ovf); end
                    rx++;
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin sb.push_back(model(in_sum, in_carry, in_tag)); sent++; have = 1'b0; end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (rx !== 1000) begin failures++; $display("FAIL b2b_count got=%0d exp=1000", rx); end
        tick(); tick();
    endtask

    task automatic test_random_stall();
        int sent;
        int rx;
        int cyc;
        logic have;
        logic acc;
        exp_t e;
        sent = 0; rx = 0; cyc = 0; have = 1'b0;
        sb.delete();
        while (rx < 10000 && cyc < 60000) begin
            if (!have && sent < 10000) begin
                in_sum = rnd128(); in_carry = rnd128(); in_tag = TAG_W'($urandom());
                have = 1'b1;
            end
            in_valid  = have && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; failures++; $display("FAIL rnd_dup cyc=%0d got=%h exp=none", cyc, out_prod);
                end else begin
                    e = sb.pop_front();
                    checks++; if ({out_prod, out_tag, out_ovf} !== e) begin failures++; $display("FAIL rnd_data n=%0d got=%h/%h/%0b exp=%h/%h/%0b", rx, out_prod, out_tag, out_ovf, e.prod, e.tag, e.ovf); end
                    rx++;
                end
            end
            acc = in_valid && in_ready;
            if (acc) begin sb.push_back(model(in_sum, in_carry, in_tag)); sent++; have = 1'b0; end
            tick();
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rx !== 10000) begin failures++; $display("FAIL rnd_count got=%0d exp=10000 cycles=%0d", rx, cyc); end
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rnd_leftover got=%0b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_split_carry();
        test_top_wrap();
        test_reset_midstream();
        test_back_pressure();
        test_back_to_back();
        test_random_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csa_final_adder_pipe.md
Name: csa_final_adder_pipe

Overview:
- Two-stage pipelined carry-propagate adder downstream of the 4:2 compressor tree in the double-precision multiplier.
- Resolves the tree's redundant sum/carry vector pair into one binary product word. Carries a sideband tag (sign/exponent) alongside the data.
- Elastic valid/ready pipeline with bubble collapsing, so the normalise/round stage can stall it.

Parameters:
W, 128, width of sum/carry vectors and of the result
SPLIT, 64, bit position of the stage-1/stage-2 split (0 < SPLIT < W)
TAG_W, 12, sideband tag width (sign plus exponent bits), passed through unchanged

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_sum/in_carry/in_tag valid this cycle
in_ready  output  1  block accepts input this cycle
in_sum  input  W  sum vector from compressor tree, weight 2^i at bit i
in_carry  input  W  carry vector from compressor tree, weight 2^(i+1) at bit i
in_tag  input  TAG_W  sideband, not interpreted
out_valid  output  1  out_prod/out_tag valid
out_ready  input  1  downstream accepts this cycle
out_prod  output  W  (in_sum + (in_carry << 1)) mod 2^W
out_tag  output  TAG_W  in_tag of the same transaction
out_ovf  output  1  carry out of bit W-1 (including in_carry[W-1] shifted out), diagnostic only

Behaviour:
- Arithmetic:
  - Define B = {in_carry[W-2:0], 1'b0}.
  - Result = in_sum + B, truncated to W bits.
  - out_ovf = in_carry[W-1] OR carry-out of the W-bit add.
- Stage 1, on accept:
  - Register lo = in_sum[SPLIT-1:0] + B[SPLIT-1:0] as SPLIT+1 bits; bit SPLIT is c1.
  - Register in_sum[W-1:SPLIT], B[W-1:SPLIT], in_carry[W-1] and in_tag unchanged.
- Stage 2, on advance:
  - Register hi = in_sum_hi + B_hi + c1.
  - out_prod = {hi[W-SPLIT-1:0], lo[SPLIT-1:0]}.
  - out_ovf = hi carry-out OR the registered in_carry[W-1].
  - out_tag = the tag registered in stage 1.
- No combinational adder spans more than max(SPLIT, W-SPLIT)+1 bits.
- Handshake:
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv, with no combinational path from in_valid.
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - Stage 1 loads when s1_adv; its valid bit becomes in_valid & in_ready.
  - Stage 2 loads when s2_adv; out_valid becomes s1_valid.
  - When a stage does not advance, its registers hold (data stable while out_valid & ~out_ready).
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput: 1 per cycle.
- Bubble collapsing: an empty stage 2 accepts stage 1 even when out_ready=0. Capacity is 2 transactions. in_ready deasserts only when both stages are full and out_ready=0.
- Simultaneous events:
  - Full pipe with out_ready=1 and in_valid=1 accepts a new input and emits an output in the same cycle.
  - Ordering is strictly FIFO.
- Reset (asynchronous, any time including mid-transfer):
  - s1_valid=0 and out_valid=0 immediately; in_transfers in flight are discarded.
  - out_prod=0, out_tag=0, out_ovf=0; all data registers clear to 0.
  - in_ready reads 1 while rst_n=0 and after release.
- Data registers may load only when their stage advances. Values with valid=0 are don't-care to downstream, but the bench checks they are 0 after reset.

Test Plan:
- Reset mid-stream: two transactions in flight, pulse rst_n low asynchronously between edges -> out_valid, out_prod, out_tag, out_ovf = 0 immediately; in_ready=1; no stale output after release.
- Split carry: in_sum=2^64-1, in_carry=0x...0 with bit0=1 (B=2), out_ready=1 -> out_prod=2^64+1, out_ovf=0. out_valid asserts exactly 2 cycles after accept.
- Top wrap: in_sum=2^127, in_carry=2^126 | 2^127 -> out_prod=0, out_ovf=1.
- Back-pressure: stream 5 random pairs with tags 1..5, hold out_ready=0 -> 2 accepted, then in_ready=0 and out_prod/out_tag stable with tag 1. Release out_ready -> tags 1..5 in order, each out_prod equal to the reference sum mod 2^128.
- Throughput: 1000 back-to-back random pairs, out_ready=1 -> one output per cycle after 2-cycle fill, all sums match, no gaps.
- Random stall: randomise in_valid and out_ready at 50% each, 10k transactions -> scoreboard match on out_prod, out_tag, out_ovf; no drops or duplicates.
